branch_resolve_unit: RTL and testbench

- Consumer end of the fetch-stage prediction interface.
- Records every prediction made at fetch (pc, predicted direction, predicted target) in an in-order FIFO and pops the matching record when the instruction reaches EX.
- Compares the record against the resolved outcome and drives flush/redirect.
- Returns a registered training packet and a committed global-history register (GHR) to the predictor. Keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Consumer side of the fetch prediction interface. Predictions made at fetch
// are queued in order; the head record is checked against the outcome
// resolved in EX, producing flush/redirect, a registered training packet,
// the committed global history and saturating statistics.
module branch_resolve_unit #(
  parameter int DEPTH   = 4,
  parameter int GHR_BIT = 5,
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_valid,
  input  logic [31:0]        if_pc,
  input  logic               if_pred_taken,
  input  logic [31:0]        if_pred_target,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_is_branch,
  input  logic               ex_is_jal,
  input  logic               ex_is_jalr,
  input  logic               ex_bcond,
  input  logic [31:0]        ex_pc_plus_imm,
  input  logic [31:0]        ex_alu_result,
  output logic               full,
  output logic               is_flush,
  output logic [31:0]        redirect_pc,
  output logic               upd_valid,
  output logic [31:0]        upd_pc,
  output logic [31:0]        upd_target,
  output logic               upd_taken,
  output logic               upd_is_branch,
  output logic [GHR_BIT-1:0] ghr,
  output logic [CNT_BIT-1:0] branch_count,
  output logic [CNT_BIT-1:0] mispredict_count,
  output logic               proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]   PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   OCC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   OCC_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_BIT-1:0] STAT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};
  localparam logic [CNT_BIT-1:0] STAT_MAX = {CNT_BIT{1'b1}};

  // One in-flight prediction: fetch pc, chosen direction, predicted target.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } rec_t;

  rec_t               fifo_q [DEPTH];
  rec_t               fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   occ_q, occ_d;

  logic               upd_valid_q, upd_valid_d;
  logic [31:0]        upd_pc_q, upd_pc_d;
  logic [31:0]        upd_target_q, upd_target_d;
  logic               upd_taken_q, upd_taken_d;
  logic               upd_is_branch_q, upd_is_branch_d;
  logic [GHR_BIT-1:0] ghr_q, ghr_d;
  logic [CNT_BIT-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_BIT-1:0] mp_cnt_q, mp_cnt_d;
  logic               perr_q, perr_d;

  rec_t        head_s;
  logic        empty_s;
  logic        resolve_s;
  logic        is_ctrl_s;
  logic        push_s;
  logic [31:0] ex_fall_s;
  logic [31:0] actual_pc_s;
  logic [31:0] taken_tgt_s;
  logic [31:0] pred_pc_s;
  logic        flush_s;

  assign full             = (occ_q == OCC_FULL);
  assign is_flush         = flush_s;
  assign redirect_pc      = flush_s ? actual_pc_s : 32'h0000_0000;
  assign upd_valid        = upd_valid_q;
  assign upd_pc           = upd_pc_q;
  assign upd_target       = upd_target_q;
  assign upd_taken        = upd_taken_q;
  assign upd_is_branch    = upd_is_branch_q;
  assign ghr              = ghr_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
  assign proto_err        = perr_q;

  // Resolve the EX outcome against the head prediction.
  always_comb begin
    head_s    = fifo_q[rd_q];
    empty_s   = (occ_q == {CNT_W{1'b0}});
    resolve_s = ex_valid & ~empty_s;
    is_ctrl_s = ex_is_branch | ex_is_jal | ex_is_jalr;
    ex_fall_s = ex_pc + 32'd4;
    if (ex_is_jal) begin
      actual_pc_s = ex_pc_plus_imm;
      taken_tgt_s = ex_pc_plus_imm;
    end else if (ex_is_jalr) begin
      actual_pc_s = ex_alu_result;
      taken_tgt_s = ex_alu_result;
    end else if (ex_is_branch) begin
      actual_pc_s = ex_bcond ? ex_pc_plus_imm : ex_fall_s;
      taken_tgt_s = ex_pc_plus_imm;
    end else begin
      actual_pc_s = ex_fall_s;
      taken_tgt_s = ex_fall_s;
    end
    pred_pc_s = head_s.taken ? head_s.tgt : (head_s.pc + 32'd4);
    flush_s   = resolve_s & (actual_pc_s != pred_pc_s);
    // A full queue refuses the push even if the head leaves this cycle.
    push_s    = if_valid & ~full & ~flush_s;
  end

  // Next state of the prediction queue; a flush discards everything, including
  // the push arriving in the same cycle, since younger records are wrong-path.
  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    if (flush_s) begin
      wr_d  = {PTR_W{1'b0}};
      rd_d  = {PTR_W{1'b0}};
      occ_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_d[wr_q] = {if_pc, if_pred_taken, if_pred_target};
        wr_d         = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (resolve_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, resolve_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Training packet, committed history, statistics and protocol error.
  always_comb begin
    upd_valid_d     = resolve_s & is_ctrl_s;
    upd_pc_d        = 32'h0000_0000;
    upd_target_d    = 32'h0000_0000;
    upd_taken_d     = 1'b0;
    upd_is_branch_d = 1'b0;
    ghr_d           = ghr_q;
    br_cnt_d        = br_cnt_q;
    mp_cnt_d        = mp_cnt_q;
    perr_d          = perr_q;
    if (upd_valid_d) begin
      upd_pc_d        = ex_pc;
      upd_target_d    = taken_tgt_s;
      upd_taken_d     = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
      upd_is_branch_d = ex_is_branch;
      if (br_cnt_q != STAT_MAX) begin
        br_cnt_d = br_cnt_q + STAT_ONE;
      end else begin
        br_cnt_d = br_cnt_q;
      end
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (resolve_s & ex_is_branch) begin
      ghr_d = {ghr_q[GHR_BIT-2:0], ex_bcond};
    end else begin
      ghr_d = ghr_q;
    end
    if (flush_s & (mp_cnt_q != STAT_MAX)) begin
      mp_cnt_d = mp_cnt_q + STAT_ONE;
    end else begin
      mp_cnt_d = mp_cnt_q;
    end
    // Sticky: EX with nothing queued, or EX pc not matching the head record.
    if ((ex_valid & empty_s) | (resolve_s & (head_s.pc != ex_pc))) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_q            <= {PTR_W{1'b0}};
      rd_q            <= {PTR_W{1'b0}};
      occ_q           <= {CNT_W{1'b0}};
      upd_valid_q     <= 1'b0;
      upd_pc_q        <= 32'h0000_0000;
      upd_target_q    <= 32'h0000_0000;
      upd_taken_q     <= 1'b0;
      upd_is_branch_q <= 1'b0;
      ghr_q           <= {GHR_BIT{1'b0}};
      br_cnt_q        <= {CNT_BIT{1'b0}};
      mp_cnt_q        <= {CNT_BIT{1'b0}};
      perr_q          <= 1'b0;
    end else begin
      fifo_q          <= fifo_d;
      wr_q            <= wr_d;
      rd_q            <= rd_d;
      occ_q           <= occ_d;
      upd_valid_q     <= upd_valid_d;
      upd_pc_q        <= upd_pc_d;
      upd_target_q    <= upd_target_d;
      upd_taken_q     <= upd_taken_d;
      upd_is_branch_q <= upd_is_branch_d;
      ghr_q           <= ghr_d;
      br_cnt_q        <= br_cnt_d;
      mp_cnt_q        <= mp_cnt_d;
      perr_q          <= perr_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_branch_resolve_unit;

  localparam int DEPTH   = 4;
  localparam int GHR_BIT = 5;
  localparam int CNT_BIT = 6;
  localparam int STAT_MAX = (1 << CNT_BIT) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               if_valid, if_pred_taken;
  logic [31:0]        if_pc, if_pred_target;
  logic               ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond;
  logic [31:0]        ex_pc, ex_pc_plus_imm, ex_alu_result;
  logic               full, is_flush, upd_valid, upd_taken, upd_is_branch, proto_err;
  logic [31:0]        redirect_pc, upd_pc, upd_target;
  logic [GHR_BIT-1:0] ghr;
  logic [CNT_BIT-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .GHR_BIT(GHR_BIT), .CNT_BIT(CNT_BIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_bcond(ex_bcond),
    .ex_pc_plus_imm(ex_pc_plus_imm), .ex_alu_result(ex_alu_result),
    .full(full), .is_flush(is_flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_branch(upd_is_branch), .ghr(ghr),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } rec_t;

  rec_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        m_upd_valid, m_upd_taken, m_upd_isbr, m_perr;
  logic [31:0] m_upd_pc, m_upd_target;
  int          m_ghr, m_bc, m_mc;
  logic        s_flush;
  logic [31:0] s_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_upd_valid = 1'b0; m_upd_taken = 1'b0; m_upd_isbr = 1'b0; m_perr = 1'b0;
    m_upd_pc = 32'h0; m_upd_target = 32'h0;
    m_ghr = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_pc = 32'h0; if_pred_taken = 1'b0; if_pred_target = 32'h0;
    ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0; ex_is_jal = 1'b0;
    ex_is_jalr = 1'b0; ex_bcond = 1'b0; ex_pc_plus_imm = 32'h0; ex_alu_result = 32'h0;
  endtask

  task automatic push_in(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = tgt;
  endtask

  // kind: 0 other, 1 branch, 2 jal, 3 jalr
  task automatic ex_in(input logic [31:0] pc, input int kind, input logic bc,
                       input logic [31:0] imm, input logic [31:0] alu);
    ex_valid = 1'b1; ex_pc = pc; ex_bcond = bc; ex_pc_plus_imm = imm; ex_alu_result = alu;
    ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
  endtask

  // Called at posedge+1 with inputs set: checks combinational outputs at the
  // negedge, advances the model, checks registered outputs after the edge.
  task automatic cycle();
    logic        resolve, flush, was_full;
    logic [31:0] actual, pred;
    #4;
    resolve = ex_valid && (q.size() != 0);
    flush = 1'b0; actual = 32'h0;
    if (resolve) begin
      if (ex_is_jal) actual = ex_pc_plus_imm;
      else if (ex_is_jalr) actual = ex_alu_result;
      else if (ex_is_branch && ex_bcond) actual = ex_pc_plus_imm;
      else actual = ex_pc + 32'd4;
      pred = q[0].taken ? q[0].tgt : q[0].pc + 32'd4;
      flush = (actual != pred);
    end
    chk("is_flush", 32'(is_flush), 32'(flush));
    chk("redirect_pc", redirect_pc, flush ? actual : 32'h0);
    s_flush = is_flush; s_redir = redirect_pc;

    if (ex_valid && (q.size() == 0 || q[0].pc != ex_pc)) m_perr = 1'b1;
    m_upd_valid = resolve && (ex_is_branch || ex_is_jal || ex_is_jalr);
    if (m_upd_valid) begin
      m_upd_pc = ex_pc;
      m_upd_target = ex_is_jalr ? ex_alu_result : ex_pc_plus_imm;
      m_upd_taken = ex_is_jal || ex_is_jalr || (ex_is_branch && ex_bcond);
      m_upd_isbr = ex_is_branch;
      if (m_bc < STAT_MAX) m_bc++;
    end
    if (resolve && ex_is_branch) m_ghr = (m_ghr * 2 + (ex_bcond ? 1 : 0)) % (1 << GHR_BIT);
    if (flush && m_mc < STAT_MAX) m_mc++;
    was_full = (q.size() == DEPTH);
    if (resolve) void'(q.pop_front());
    if (flush) q.delete();
    else if (if_valid && !was_full) q.push_back('{if_pc, if_pred_taken, if_pred_target});

    @(posedge clk); #1;
    chk("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
    if (m_upd_valid) begin
      chk("upd_pc", upd_pc, m_upd_pc);
      chk("upd_target", upd_target, m_upd_target);
      chk("upd_taken", 32'(upd_taken), 32'(m_upd_taken));
      chk("upd_is_branch", 32'(upd_is_branch), 32'(m_upd_isbr));
    end
    chk("ghr", 32'(ghr), 32'(m_ghr));
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    idle();
  endtask

  task automatic rand_stim();
    int   k;
    rec_t h;
    idle();
    if_valid = ($urandom_range(0, 3) != 0);
    if_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    if_pred_taken = $urandom_range(0, 1) == 1;
    if_pred_target = ($urandom_range(0, 3) == 0) ? if_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
    if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, 3);
      if (q.size() != 0) begin
        h = q[0];
        ex_in(($urandom_range(0, 19) == 0) ? $urandom : h.pc, k, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? h.tgt : $urandom,
              ($urandom_range(0, 1) == 1) ? h.tgt : $urandom);
      end else begin
        ex_in($urandom, k, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_ghr"}, 32'(ghr), 32'd0);
    chk({tag, "_branch_count"}, 32'(branch_count), 32'd0);
    chk({tag, "_mispredict_count"}, 32'(mispredict_count), 32'd0);
    chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 1'b0;
    #12;
    reset_checks("rst");
    chk("rst_is_flush", 32'(is_flush), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Non-control instructions predicted not-taken: never a flush or packet.
    push_in(32'h00, 1'b0, 32'h0); cycle();
    push_in(32'h04, 1'b0, 32'h0); cycle();
    push_in(32'h08, 1'b0, 32'h0); cycle();
    for (int i = 0; i < 3; i++) begin
      ex_in(32'(i * 4), 0, 1'b0, 32'h0, 32'h0); cycle();
      chk("t1_flush_lit", 32'(s_flush), 32'd0);
      chk("t1_upd_valid_lit", 32'(upd_valid), 32'd0);
    end

    // Taken branch predicted not-taken; concurrent push is dropped.
    push_in(32'h10, 1'b0, 32'h0); cycle();
    ex_in(32'h10, 1, 1'b1, 32'h40, 32'h0); push_in(32'h14, 1'b0, 32'h0); cycle();
    chk("t2_flush_lit", 32'(s_flush), 32'd1);
    chk("t2_redirect_lit", s_redir, 32'h40);
    chk("t2_upd_valid_lit", 32'(upd_valid), 32'd1);
    chk("t2_upd_taken_lit", 32'(upd_taken), 32'd1);
    chk("t2_upd_target_lit", upd_target, 32'h40);
    chk("t2_ghr_lit", 32'(ghr), 32'd1);
    chk("t2_mispred_lit", 32'(mispredict_count), 32'd1);

    // Correctly predicted jal.
    push_in(32'h20, 1'b1, 32'h80); cycle();
    ex_in(32'h20, 2, 1'b0, 32'h80, 32'h0); cycle();
    chk("t3_flush_lit", 32'(s_flush), 32'd0);
    chk("t3_upd_isbr_lit", 32'(upd_is_branch), 32'd0);
    chk("t3_ghr_lit", 32'(ghr), 32'd1);
    chk("t3_branch_count_lit", 32'(branch_count), 32'd2);

    // jalr target differing only in bit 0 still redirects, unmasked.
    push_in(32'h30, 1'b1, 32'h100); cycle();
    ex_in(32'h30, 3, 1'b0, 32'h0, 32'h101); cycle();
    chk("t4_flush_lit", 32'(s_flush), 32'd1);
    chk("t4_redirect_lit", s_redir, 32'h101);

    // Fill the queue; a push alongside a pop while full is refused.
    for (int i = 0; i < DEPTH; i++) begin
      push_in(32'h100 + 32'(i * 4), 1'b0, 32'h0); cycle();
    end
    chk("t5_full_lit", 32'(full), 32'd1);
    push_in(32'h200, 1'b0, 32'h0); ex_in(32'h100, 0, 1'b0, 32'h0, 32'h0); cycle();
    chk("t5_full_after_pop_lit", 32'(full), 32'd0);
    push_in(32'h200, 1'b0, 32'h0); cycle();
    chk("t5_full_again_lit", 32'(full), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      ex_in(32'h100 + 32'(i * 4), 0, 1'b0, 32'h0, 32'h0); cycle();
    end
    ex_in(32'h200, 0, 1'b0, 32'h0, 32'h0); cycle();
    chk("t5_proto_clean_lit", 32'(proto_err), 32'd0);

    // Resolution with an empty queue.
    ex_in(32'h300, 1, 1'b1, 32'h0, 32'h0); cycle();
    chk("t6_proto_err_lit", 32'(proto_err), 32'd1);

    for (int n = 0; n < 1500; n++) begin
      rand_stim(); cycle();
    end

    // Asynchronous reset between clock edges.
    push_in(32'h400, 1'b0, 32'h0); cycle();
    reset_n = 1'b0;
    #2;
    reset_checks("midrst");
    model_reset();
    idle();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    cycle();
    chk("midrst_no_upd_lit", 32'(upd_valid), 32'd0);
    for (int n = 0; n < 300; n++) begin
      rand_stim(); cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
